fb_write_arbiter: RTL and testbench

Shares the single framebuffer write port between the three pixel producers of the paint subsystem: the paint controller (committed pixels), the cursor drawer and the palette-cursor drawer. Each producer presents a pixel write (x, y, data) on a valid/ready handshake. The block selects one winner per cycle by fixed priority with a starvation override, and drives the framebuffer through a one-entry registered output stage that holds while the framebuffer stalls. It sits between the paint control FSM and its drawing engines on one side and the framebuffer RAM on the other.

---
 rtl/paint_pkg.sv | 15 +
 rtl/fb_prio_pick.sv | 33 +++
 rtl/fb_write_arbiter.sv | 96 +++++++++
 tb/tb_fb_write_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// Shared constants and types for the paint subsystem framebuffer path.
package paint_pkg;

   localparam int unsigned N_REQ   = 3;
   localparam int unsigned COORD_W = 8;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned IDX_W   = 2;

   localparam int unsigned REQ_PAINT  = 0;
   localparam int unsigned REQ_CURSOR = 1;
   localparam int unsigned REQ_PALETA = 2;

   typedef enum logic {StEmpty, StFull} out_state_e;

endpackage

// File: rtl/fb_prio_pick.sv
// Combinational winner selection: lowest starved requester first, else lowest valid.
module fb_prio_pick
   import paint_pkg::*;
(
   input  logic [N_REQ-1:0] valid,
   input  logic [N_REQ-1:0] starve,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (valid[i] && starve[i] && !found) begin
            grant[i]  = 1'b1;
            grant_idx = IDX_W'(i);
            found     = 1'b1;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (valid[i] && !found) begin
            grant[i]  = 1'b1;
            grant_idx = IDX_W'(i);
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Arbitrates three pixel producers onto one framebuffer write port through a
// one-entry registered output stage that holds while the framebuffer stalls.
module fb_write_arbiter
   import paint_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*COORD_W-1:0] req_x,
   input  logic [N_REQ*COORD_W-1:0] req_y,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   input  logic                     fb_stall,
   output logic                     fb_we,
   output logic [COORD_W-1:0]       fb_x,
   output logic [COORD_W-1:0]       fb_y,
   output logic [DATA_W-1:0]        fb_data,
   output logic [IDX_W-1:0]         grant_id,
   output logic                     busy
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   out_state_e       state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q [N_REQ];
   logic [N_REQ-1:0] starve;
   logic [N_REQ-1:0] pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             accept;
   logic             load;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         starve[i] = (wait_cnt_q[i] == CNT_W'(STARVE_MAX));
      end
   end

   fb_prio_pick u_pick (
      .valid     (req_valid),
      .starve    (starve),
      .grant     (pick_oh),
      .grant_idx (pick_idx)
   );

   // Stall only blocks draining; an empty stage always captures.
   assign accept = (state_q == StEmpty) || !fb_stall;
   assign load   = accept && (|req_valid);

   assign req_ready = (load ? pick_oh : '0) & {N_REQ{rst}};
   assign fb_we     = (state_q == StFull);
   assign busy      = fb_we || (|req_valid);

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = load ? StFull : StEmpty;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StEmpty;
         fb_x     <= '0;
         fb_y     <= '0;
         fb_data  <= '0;
         grant_id <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            fb_x     <= req_x[pick_idx*COORD_W +: COORD_W];
            fb_y     <= req_y[pick_idx*COORD_W +: COORD_W];
            fb_data  <= req_data[pick_idx*DATA_W +: DATA_W];
            grant_id <= pick_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            wait_cnt_q[i] <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < N_REQ; i++) begin
            if ((load && pick_oh[i]) || !req_valid[i]) begin
               wait_cnt_q[i] <= '0;
            end else if (!starve[i]) begin
               wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench: stimulus pushes expected writes, a monitor pops on each completed write.
module tb_fb_write_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [23:0] req_x;
   logic [23:0] req_y;
   logic [23:0] req_data;
   logic        fb_stall;
   logic        fb_we;
   logic [7:0]  fb_x;
   logic [7:0]  fb_y;
   logic [7:0]  fb_data;
   logic [1:0]  grant_id;
   logic        busy;

   logic [7:0] px [3];
   logic [7:0] py [3];
   logic [7:0] pd [3];

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] d;
   } wr_t;

   wr_t exp_q [$];
   int  n_cmp = 0;
   int  n_bad = 0;

   assign req_x    = {px[2], px[1], px[0]};
   assign req_y    = {py[2], py[1], py[0]};
   assign req_data = {pd[2], pd[1], pd[0]};

   fb_write_arbiter #(.STARVE_MAX(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_data  (req_data),
      .fb_stall  (fb_stall),
      .fb_we     (fb_we),
      .fb_x      (fb_x),
      .fb_y      (fb_y),
      .fb_data   (fb_data),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] d);
      px[i] = x;
      py[i] = y;
      pd[i] = d;
   endtask

   // Called at a falling edge; drives one cycle and checks the expected grant.
   task automatic step(input logic [2:0] v, input logic stall, input logic [2:0] exp_rdy,
                       input string name);
      wr_t w;
      req_valid = v;
      fb_stall  = stall;
      #1;
      chk(name, {29'd0, req_ready}, {29'd0, exp_rdy});
      for (int i = 0; i < 3; i++) begin
         if (exp_rdy[i]) begin
            w.id = 2'(i);
            w.x  = px[i];
            w.y  = py[i];
            w.d  = pd[i];
            exp_q.push_back(w);
         end
      end
      @(negedge clk);
   endtask

   // Monitor: a write completes on any edge where the stage is full and not stalled.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst && fb_we && !fb_stall) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {6'd0, grant_id, fb_x, fb_y, fb_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("fb_write", {6'd0, grant_id, fb_x, fb_y, fb_data}, {6'd0, e});
            end
         end
      end
   end

   initial begin
      rst       = 1'b0;
      req_valid = 3'b111;
      fb_stall  = 1'b0;
      for (int i = 0; i < 3; i++) set_req(i, 8'h00, 8'h00, 8'h00);

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_ready", {29'd0, req_ready}, 32'd0);
      chk("rst_we", {31'd0, fb_we}, 32'd0);
      chk("rst_out", {6'd0, grant_id, fb_x, fb_y, fb_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      req_valid = 3'b000;
      rst       = 1'b1;
      @(negedge clk);

      // Single write from cursor
      set_req(1, 8'h12, 8'h34, 8'hA5);
      step(3'b010, 1'b0, 3'b010, "single_acc");
      chk("single_we", {31'd0, fb_we}, 32'd1);
      chk("single_busy", {31'd0, busy}, 32'd1);
      step(3'b000, 1'b0, 3'b000, "single_idle");
      chk("single_we_fall", {31'd0, fb_we}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Fixed priority
      set_req(0, 8'h01, 8'h02, 8'h03);
      set_req(1, 8'h11, 8'h12, 8'h13);
      set_req(2, 8'h21, 8'h22, 8'h23);
      step(3'b111, 1'b0, 3'b001, "prio_0");
      step(3'b110, 1'b0, 3'b010, "prio_1");
      step(3'b100, 1'b0, 3'b100, "prio_2");
      step(3'b000, 1'b0, 3'b000, "prio_idle");

      // Starvation: 2 wins every 16th accept while 0 stays valid
      set_req(0, 8'hA0, 8'hA1, 8'hA2);
      set_req(2, 8'hC0, 8'hC1, 8'hC2);
      for (int k = 1; k <= 32; k++) begin
         step(3'b101, 1'b0, (k == 16 || k == 32) ? 3'b100 : 3'b001, $sformatf("starve_%0d", k));
      end
      step(3'b000, 1'b0, 3'b000, "starve_idle");

      // Stall holds the output stage; release lets the pending write load
      set_req(0, 8'h5A, 8'h6B, 8'h7C);
      set_req(1, 8'hE1, 8'hE2, 8'hE3);
      step(3'b001, 1'b0, 3'b001, "stall_acc");
      for (int k = 0; k < 5; k++) begin
         step(3'b010, 1'b1, 3'b000, "stall_ready");
         chk("stall_hold", {6'd0, grant_id, fb_x, fb_y, fb_data}, 32'h005A_6B7C);
      end
      step(3'b010, 1'b0, 3'b010, "stall_release");
      step(3'b000, 1'b0, 3'b000, "stall_idle");

      // Capture while EMPTY even though stalled
      set_req(0, 8'h3C, 8'h4D, 8'h5E);
      step(3'b001, 1'b1, 3'b001, "cap_acc");
      for (int k = 0; k < 3; k++) begin
         chk("cap_we_hold", {31'd0, fb_we}, 32'd1);
         step(3'b000, 1'b1, 3'b000, "cap_stalled");
      end
      step(3'b000, 1'b0, 3'b000, "cap_drain");
      chk("cap_we_fall", {31'd0, fb_we}, 32'd0);

      // Reset mid-write discards the held write
      set_req(2, 8'h77, 8'h66, 8'h55);
      step(3'b100, 1'b0, 3'b100, "rstw_acc");
      set_req(2, 8'h11, 8'h22, 8'h33);
      step(3'b100, 1'b1, 3'b000, "rstw_stalled");
      rst = 1'b0;
      #1;
      void'(exp_q.pop_back());
      chk("rstw_we", {31'd0, fb_we}, 32'd0);
      chk("rstw_out", {6'd0, grant_id, fb_x, fb_y, fb_data}, 32'd0);
      chk("rstw_ready", {29'd0, req_ready}, 32'd0);
      fb_stall = 1'b0;
      @(negedge clk);
      #1;
      chk("rstw_ready_hold", {29'd0, req_ready}, 32'd0);
      @(negedge clk);
      req_valid = 3'b000;
      rst       = 1'b1;

      repeat (3) @(negedge clk);
      #3;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
